// File: rtl/fixed_point_div_pkg.sv
// fixed_point_div_pkg: FSM states and id-width helper shared by the divider arbiter
package fixed_point_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fixed_point_div_arbiter_div.sv
// comb_FixedPointDiv: combinational signed fixed-point divide, round-to-nearest, saturating
module comb_FixedPointDiv #(
  parameter int WIIA = 8,
  parameter int WIFA = 8,
  parameter int WIIB = 8,
  parameter int WIFB = 8,
  parameter int WOI = 8,
  parameter int WOF = 8,
  parameter int ROUND = 1,
  parameter int ROOF = 1
) (
  input  logic [WIIA+WIFA-1:0] dividend,
  input  logic [WIIB+WIFB-1:0] divisor,
  output logic [WOI+WOF-1:0]   out,
  output logic                 upflow,
  output logic                 downflow
);
  localparam int WA = WIIA + WIFA;
  localparam int WB = WIIB + WIFB;
  localparam int WO = WOI + WOF;
  localparam int WN = WA + WOF + WIFB;
  localparam int WD = WB + WIFA;
  localparam int WX = (WN > WD) ? WN : WD;
  localparam int WM = ((WX > WO) ? WX : WO) + 2;
  localparam logic [WM-1:0] MAXP = (WM'(1) << (WO - 1)) - WM'(1);
  localparam logic [WM-1:0] MAXN = WM'(1) << (WO - 1);
  logic neg;
  logic [WA-1:0] aa;
  logic [WB-1:0] bb;
  logic [WM-1:0] num, den, dn, q, r, mq;
  logic [WO-1:0] wq;
  // work on magnitudes so rounding is symmetric about zero
  always_comb begin
    neg = dividend[WA-1] ^ divisor[WB-1];
    aa = dividend[WA-1] ? -dividend : dividend;
    bb = divisor[WB-1] ? -divisor : divisor;
    num = WM'(aa) << (WOF + WIFB);
    den = WM'(bb) << WIFA;
    dn = (den == '0) ? WM'(1) : den;
    q = num / dn;
    r = num % dn;
    mq = q + WM'(ROUND != 0 && (r << 1) >= dn);
    upflow = !neg && mq > MAXP;
    downflow = neg && mq > MAXN;
    wq = neg ? -mq[WO-1:0] : mq[WO-1:0];
    out = (ROOF != 0 && upflow) ? MAXP[WO-1:0] : (ROOF != 0 && downflow) ? MAXN[WO-1:0] : wq;
  end
endmodule

// File: rtl/fixed_point_div_arbiter.sv
// fixed_point_div_arbiter: round-robin arbiter sharing one fixed-point divider among NREQ requesters
module fixed_point_div_arbiter
  import fixed_point_div_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIIA = 8,
  parameter int WIFA = 8,
  parameter int WIIB = 8,
  parameter int WIFB = 8,
  parameter int WOI = 8,
  parameter int WOF = 8,
  parameter int ROUND = 1
) (
  input  logic                           rstn,
  input  logic                           clk,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ*(WIIA+WIFA)-1:0]    req_dividend,
  input  logic [NREQ*(WIIB+WIFB)-1:0]    req_divisor,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [id_w(NREQ)-1:0]          out_id,
  output logic [WOI+WOF-1:0]             out_quot,
  output logic                           out_upflow,
  output logic                           out_downflow,
  output logic                           out_dbz
);
  localparam int WA = WIIA + WIFA;
  localparam int WB = WIIB + WIFB;
  localparam int WO = WOI + WOF;
  localparam int IW = id_w(NREQ);
  state_t state;
  logic [IW-1:0] ptr, gnt, id_r;
  logic [WA-1:0] a_r;
  logic [WB-1:0] b_r;
  logic [WO-1:0] d_quot;
  logic hit, dbz, neg, d_up, d_dn;
  // first valid requester after the last winner, wrapping around
  always_comb begin
    hit = 1'b0;
    gnt = ptr;
    for (int k = 1; k <= NREQ; k++) begin
      if (!hit && req_valid[IW'((int'(ptr) + k) % NREQ)]) begin
        hit = 1'b1;
        gnt = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end
  assign req_ready = (state == IDLE && hit) ? {{(NREQ-1){1'b0}}, 1'b1} << gnt : '0;
  assign dbz = b_r == '0;
  assign neg = a_r[WA-1];
  comb_FixedPointDiv #(
    .WIIA(WIIA), .WIFA(WIFA), .WIIB(WIIB), .WIFB(WIFB),
    .WOI(WOI), .WOF(WOF), .ROUND(ROUND), .ROOF(1)
  ) u_div (
    .dividend(a_r),
    .divisor(b_r),
    .out(d_quot),
    .upflow(d_up),
    .downflow(d_dn)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      ptr <= IW'(NREQ - 1);
      a_r <= '0;
      b_r <= '0;
      id_r <= '0;
      out_valid <= 1'b0;
      out_id <= '0;
      out_quot <= '0;
      out_upflow <= 1'b0;
      out_downflow <= 1'b0;
      out_dbz <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          a_r <= req_dividend[gnt*WA +: WA];
          b_r <= req_divisor[gnt*WB +: WB];
          id_r <= gnt;
          ptr <= gnt;
          state <= CALC;
        end
        CALC: begin
          out_valid <= 1'b1;
          out_id <= id_r;
          out_quot <= dbz ? (neg ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}}) : d_quot;
          out_upflow <= dbz ? !neg : d_up;
          out_downflow <= dbz ? neg : d_dn;
          out_dbz <= dbz;
          state <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
